// File: rtl/hazard_control_pkg.sv
// Shared definitions for the pipeline hazard controller:
// instruction field positions, opcodes and FSM states.
package hazard_control_pkg;

    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RD_HI = 26;
    localparam int RD_LO = 22;
    localparam int RS_HI = 21;
    localparam int RS_LO = 17;
    localparam int RT_HI = 16;
    localparam int RT_LO = 12;

    localparam logic [4:0] OPC_ALU  = 5'b00000;
    localparam logic [4:0] OPC_ADDI = 5'b00101;
    localparam logic [4:0] OPC_SW   = 5'b00111;
    localparam logic [4:0] OPC_LW   = 5'b01000;
    localparam logic [4:0] OPC_BNE  = 5'b00010;
    localparam logic [4:0] OPC_BLT  = 5'b00110;
    localparam logic [4:0] OPC_JR   = 5'b00100;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } hc_state_e;

    function automatic logic [4:0] f_op(input logic [31:0] ir);
        return ir[OP_HI:OP_LO];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] ir);
        return ir[RD_HI:RD_LO];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] ir);
        return ir[RS_HI:RS_LO];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] ir);
        return ir[RT_HI:RT_LO];
    endfunction

endpackage

// File: rtl/hazard_dep_check.sv
// Load-use detector: does the F/D instruction read the
// register a D/X load is about to write?
module hazard_dep_check
    import hazard_control_pkg::*;
(
    input  logic [31:0] fd_ir_i,
    input  logic [31:0] dx_ir_i,
    output logic        load_use_o
);

    logic [4:0] fd_op;
    logic [4:0] dx_rd;
    logic       use_rs;
    logic       use_rt;
    logic       use_rd;
    logic       unused;

    assign fd_op  = f_op(fd_ir_i);
    assign dx_rd  = f_rd(dx_ir_i);
    assign unused = ^{fd_ir_i[11:0], dx_ir_i[21:0]};

    // Which source fields the F/D instruction actually reads.
    always_comb begin
        use_rs = 1'b0;
        use_rt = 1'b0;
        use_rd = 1'b0;
        unique case (fd_op)
            OPC_ALU: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OPC_ADDI, OPC_LW: use_rs = 1'b1;
            OPC_SW, OPC_BNE, OPC_BLT: begin
                use_rs = 1'b1;
                use_rd = 1'b1;
            end
            OPC_JR: use_rd = 1'b1;
            default: ;
        endcase
    end

    // r0 is hardwired, so a load into it never creates a hazard.
    always_comb begin
        load_use_o = (f_op(dx_ir_i) == OPC_LW) && (dx_rd != 5'd0) &&
                     ((use_rs && f_rs(fd_ir_i) == dx_rd) ||
                      (use_rt && f_rt(fd_ir_i) == dx_rd) ||
                      (use_rd && f_rd(fd_ir_i) == dx_rd));
    end

endmodule

// File: rtl/hazard_control.sv
// Pipeline stall/flush controller: load-use bubbles, branch
// squash and mult/div wait with timeout and stall counter.
module hazard_control
    import hazard_control_pkg::*;
#(
    parameter int MD_TIMEOUT  = 63,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [31:0]            fd_ir,
    input  logic [31:0]            dx_ir,
    input  logic                   branch_taken,
    input  logic                   md_start,
    input  logic                   md_ready,
    output logic                   pc_enable,
    output logic                   fd_block,
    output logic                   dx_block,
    output logic                   xm_block,
    output logic                   mw_block,
    output logic                   fd_flush,
    output logic                   dx_flush,
    output logic                   xm_flush,
    output logic                   md_timeout,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int CW = (MD_TIMEOUT < 1) ? 1 : $clog2(MD_TIMEOUT + 1);

    hc_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   tmo_q, tmo_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   load_use;

    hazard_dep_check u_dep (
        .fd_ir_i    (fd_ir),
        .dx_ir_i    (dx_ir),
        .load_use_o (load_use)
    );

    assign xm_block    = 1'b0;
    assign mw_block    = 1'b0;
    assign md_timeout  = tmo_q;
    assign stall_count = stall_q;

    // Control outputs and next state from current state and inputs.
    always_comb begin
        pc_enable = 1'b1;
        fd_block  = 1'b0;
        dx_block  = 1'b0;
        fd_flush  = 1'b0;
        dx_flush  = 1'b0;
        xm_flush  = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        if (!resetn) begin
            pc_enable = 1'b0;
            fd_flush  = 1'b1;
            dx_flush  = 1'b1;
            xm_flush  = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (branch_taken) begin
                        fd_flush = 1'b1;
                        dx_flush = 1'b1;
                    end else begin
                        if (load_use) begin
                            pc_enable = 1'b0;
                            fd_block  = 1'b1;
                            dx_flush  = 1'b1;
                        end
                        if (md_start) begin
                            state_d = ST_MD_WAIT;
                            cnt_d   = '0;
                        end
                    end
                end
                ST_MD_WAIT: begin
                    if (md_ready) begin
                        state_d = ST_RUN;
                    end else begin
                        pc_enable = 1'b0;
                        fd_block  = 1'b1;
                        dx_block  = 1'b1;
                        xm_flush  = 1'b1;
                        if (cnt_q == CW'(MD_TIMEOUT)) begin
                            tmo_d   = 1'b1;
                            state_d = ST_RUN;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_comb begin
        stall_d = stall_q;
        if (!pc_enable && (stall_q != '1)) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    // State, wait counter, sticky timeout and stall counter.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_hazard_control.sv
// Randomized and directed bench for hazard_control against
// a behavioural model of the stall/flush rules.
module tb_hazard_control;

    localparam int TMO  = 63;
    localparam int SW   = 8;
    localparam int SMAX = (1 << SW) - 1;

    logic          clock = 1'b0;
    logic          resetn;
    logic [31:0]   fd_ir;
    logic [31:0]   dx_ir;
    logic          branch_taken;
    logic          md_start;
    logic          md_ready;
    logic          pc_enable;
    logic          fd_block;
    logic          dx_block;
    logic          xm_block;
    logic          mw_block;
    logic          fd_flush;
    logic          dx_flush;
    logic          xm_flush;
    logic          md_timeout;
    logic [SW-1:0] stall_count;

    int n_chk  = 0;
    int n_fail = 0;

    bit m_wait   = 0;
    int m_waited = 0;
    bit m_tmo    = 0;
    int m_stall  = 0;

    always #5 clock = ~clock;

    hazard_control #(
        .MD_TIMEOUT  (TMO),
        .STALL_CNT_W (SW)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .fd_ir        (fd_ir),
        .dx_ir        (dx_ir),
        .branch_taken (branch_taken),
        .md_start     (md_start),
        .md_ready     (md_ready),
        .pc_enable    (pc_enable),
        .fd_block     (fd_block),
        .dx_block     (dx_block),
        .xm_block     (xm_block),
        .mw_block     (mw_block),
        .fd_flush     (fd_flush),
        .dx_flush     (dx_flush),
        .xm_flush     (xm_flush),
        .md_timeout   (md_timeout),
        .stall_count  (stall_count)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int rd,
                                       input int rs, input int rt);
        return {op[4:0], rd[4:0], rs[4:0], rt[4:0], 12'h000};
    endfunction

    // Registers read by an instruction, listed per opcode.
    function automatic bit lu(input logic [31:0] f, input logic [31:0] d);
        int srcs[$];
        int drd;
        int rs;
        int rt;
        int rd;
        drd = int'(d[26:22]);
        rd  = int'(f[26:22]);
        rs  = int'(f[21:17]);
        rt  = int'(f[16:12]);
        if (d[31:27] != 5'd8 || drd == 0) return 1'b0;
        case (int'(f[31:27]))
            0:       srcs = '{rs, rt};
            5, 8:    srcs = '{rs};
            7, 2, 6: srcs = '{rs, rd};
            4:       srcs = '{rd};
            default: srcs = {};
        endcase
        foreach (srcs[i]) if (srcs[i] == drd) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input logic [31:0] f, input logic [31:0] d,
                        input bit br, input bit ms, input bit mr,
                        input bit rn);
        bit [7:0] e;
        fd_ir        = f;
        dx_ir        = d;
        branch_taken = br;
        md_start     = ms;
        md_ready     = mr;
        resetn       = rn;
        if (!rn) begin
            m_wait   = 0;
            m_waited = 0;
            m_tmo    = 0;
            m_stall  = 0;
        end
        // order: pc, fdb, dxb, xmb, mwb, fdf, dxf, xmf
        if (!rn)                e = 8'b0000_0111;
        else if (m_wait && !mr) e = 8'b0110_0001;
        else if (m_wait)        e = 8'b1000_0000;
        else if (br)            e = 8'b1000_0110;
        else if (lu(f, d))      e = 8'b0100_0010;
        else                    e = 8'b1000_0000;
        @(negedge clock);
        check("ctl",
              {pc_enable, fd_block, dx_block, xm_block, mw_block,
               fd_flush, dx_flush, xm_flush, md_timeout},
              {e, m_tmo});
        check("stall", stall_count, m_stall);
        @(posedge clock);
        if (rn) begin
            if (!e[7] && m_stall < SMAX) m_stall++;
            if (m_wait) begin
                if (mr) m_wait = 0;
                else begin
                    m_waited++;
                    if (m_waited == TMO + 1) begin
                        m_tmo  = 1;
                        m_wait = 0;
                    end
                end
            end else if (ms && !br) begin
                m_wait   = 1;
                m_waited = 0;
            end
        end
        #1;
    endtask

    task automatic idle(input bit mr);
        step(32'h0, 32'h0, 0, 0, mr, 1);
    endtask

    task automatic do_reset();
        step(32'h0, 32'h0, 0, 0, 0, 0);
        step(32'h0, 32'h0, 0, 0, 0, 0);
    endtask

    logic [31:0] add_i;
    logic [31:0] lw_i;
    logic [31:0] lw0_i;
    int          ops[10] = '{0, 5, 7, 8, 2, 6, 4, 1, 3, 9};

    initial begin
        add_i = mk(0, 4, 3, 2);
        lw_i  = mk(8, 3, 1, 0);
        lw0_i = mk(8, 0, 1, 0);

        do_reset();
        check("rst_pc", pc_enable, 1'b0);

        // load-use bubble
        step(add_i, lw_i, 0, 0, 0, 1);
        idle(0);
        check("lu_stall", stall_count, 1);

        // load into r0 is not a hazard
        do_reset();
        step(add_i, lw0_i, 0, 0, 0, 1);
        check("lu_r0_stall", stall_count, 0);

        // branch wins over load-use
        do_reset();
        step(add_i, lw_i, 1, 0, 0, 1);
        check("br_stall", stall_count, 0);

        // mult/div with ready after 5 cycles
        do_reset();
        step(32'h0, 32'h0, 0, 1, 0, 1);
        repeat (5) idle(0);
        idle(1);
        idle(0);
        check("md5_stall", stall_count, 5);

        // mult/div timeout
        do_reset();
        step(32'h0, 32'h0, 0, 1, 0, 1);
        repeat (64) idle(0);
        check("md_tmo", md_timeout, 1'b1);
        check("md_tmo_stall", stall_count, 64);
        idle(0);
        step(add_i, lw_i, 0, 0, 0, 1);
        check("tmo_sticky", md_timeout, 1'b1);
        do_reset();
        check("tmo_clear", md_timeout, 1'b0);

        // reset during MD_WAIT
        step(32'h0, 32'h0, 0, 1, 0, 1);
        idle(0);
        idle(0);
        step(32'h0, 32'h0, 0, 0, 0, 0);
        idle(0);
        check("rst_wait_pc", pc_enable, 1'b1);
        check("rst_wait_stall", stall_count, 0);

        // stall counter saturation
        do_reset();
        repeat (5) begin
            step(32'h0, 32'h0, 0, 1, 0, 1);
            repeat (64) idle(0);
        end
        check("sat", stall_count, SMAX);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] f;
            logic [31:0] d;
            bit          br;
            bit          ms;
            bit          mr;
            bit          rn;
            f  = mk(ops[$urandom_range(0, 9)], $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
            d  = mk(($urandom_range(0, 1) == 1) ? 8 : ops[$urandom_range(0, 9)],
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3));
            br = ($urandom_range(0, 7) == 0);
            ms = ($urandom_range(0, 9) == 0);
            mr = ((i % 1000) < 300) ? 1'b0 : ($urandom_range(0, 3) == 0);
            rn = ($urandom_range(0, 299) != 0);
            step(f, d, br, ms, mr, rn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
